spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
//  Shares one spi_controller between N_REQ requesters (e.g. display writer, touch poller).
//  Round-robin picks one pending request, presents it to the controller, tracks it to
//  completion and routes read data back to the winner. Optional lock keeps the grant for
//  multi-transaction sequences. A watchdog recovers from a controller that never finishes.
// PARAMETERS
//  N_REQ        2      number of requesters, 2..8
//  TIMEOUT      4096   max clk cycles in S_WAIT_BUSY + S_WAIT_DONE before abort
// PORTS
//  clk            in   1          system clock
//  rst            in   1          asynchronous, active-high reset
//  req_valid      in   N_REQ      requester i has a transaction pending
//  req_ready      out  N_REQ      requester i's request accepted this cycle
//  req_mode       in   N_REQ x spi_transaction_t   per-requester mode
//  req_data       in   N_REQ x 16 per-requester tx data
//  req_lock       in   N_REQ      keep grant after current transaction completes
//  rsp_done       out  N_REQ      1-cycle pulse: requester i's transaction finished
//  rsp_valid      out  N_REQ      1-cycle pulse: read-mode finished, rsp_data valid
//  rsp_err        out  N_REQ      1-cycle pulse: watchdog abort of requester i
//  rsp_data       out  24         last read result, shared, held until next read
//  spi_i_valid    out  1          to controller i_valid
//  spi_i_ready    in   1          from controller i_ready
//  spi_mode       out  spi_transaction_t  to controller spi_mode (registered)
//  spi_i_data     out  16         to controller i_data (registered)
//  spi_o_data     in   24         from controller o_data
//  grant          out  $clog2(N_REQ)  index of current/last owner
//  busy           out  1          state != S_IDLE
// BEHAVIOUR
//  Reset: state S_IDLE, rr pointer 0, grant 0, lock_held 0, all req_ready/rsp_* 0,
//   spi_i_valid 0, spi_mode WRITE_8, spi_i_data 0, rsp_data 0, watchdog 0.
//  Winner (comb): if lock_held, only grant is eligible; else first i with req_valid
//   searching from rr pointer upward, wrapping mod N_REQ.
//  req_ready[i] = (state==S_IDLE) & winner valid & (i==winner); transfer = valid&ready.
//  S_IDLE: on transfer, capture mode/data into spi_mode/spi_i_data, grant<=winner,
//   -> S_ISSUE. No valid request (or locked owner idle): stay.
//  S_ISSUE: spi_i_valid=1; when spi_i_ready==1 same cycle -> S_WAIT_BUSY, drop valid.
//  S_WAIT_BUSY: wait spi_i_ready==0 (controller left idle) -> S_WAIT_DONE.
//  S_WAIT_DONE: on spi_i_ready==1: rsp_done[grant]=1; if read mode, rsp_data<=spi_o_data
//   and rsp_valid[grant]=1 same cycle; lock_held<=req_lock[grant]; if !req_lock[grant]
//   rr pointer<=grant+1 (wrap). -> S_IDLE.
//  Latency: request accept -> spi_i_valid 1 cycle; completion -> rsp pulse 1 cycle after
//   controller i_ready rises. Back-to-back: next accept the cycle after rsp_done.
//  Watchdog: counts in S_WAIT_BUSY/S_WAIT_DONE; reaching TIMEOUT-1 -> rsp_err[grant]=1,
//   lock_held<=0, rr advances, -> S_IDLE; no rsp_done/rsp_valid for that request.
//  Lock release: lock_held clears when owner completes with req_lock=0, or on abort.
//   While lock_held, other requesters' req_ready stays 0 even if owner has no request.
//  Requester drops req_valid after accept: no effect, data already captured.
//  req_valid while busy: ignored until S_IDLE; requests never lost, never duplicated.
//  Reset mid-transaction: immediate return to reset state; no rsp pulse emitted.
//  Unknown spi_mode treated as read (controller does the same); is_read from package.
// STRUCTURE
//  spi_types package: existing spi_transaction_t; add function is_read_mode(mode)
//   (WRITE_8/WRITE_16 -> 0, all else 1). Arbiter state enum stays local.
//  Sub-module rr_priority_picker: comb, N_REQ-wide request vector + pointer -> one-hot
//   grant + index + any; reusable for other shared buses.
// TESTING
//  1 Single write: req0 WRITE_16 data 16'hA55A -> spi_i_data=A55A, rsp_done[0] pulse,
//    no rsp_valid, grant=0.
//  2 Single read: req1 WRITE_8_READ_24, model returns 24'h123456 -> rsp_valid[1] and
//    rsp_done[1] same cycle, rsp_data=123456, held through a later write.
//  3 Contention: req0 and req1 held valid for 6 transactions -> grants 0,1,0,1,0,1.
//  4 Lock: req0 lock=1 for 3 writes while req1 pending -> 0,0,0 then 1; req1 ready stays 0.
//  5 Watchdog, TIMEOUT=16: model never re-raises i_ready -> rsp_err[grant] at 16 cycles,
//    busy=0, next request served normally.
//  6 Async rst asserted in S_WAIT_DONE -> all outputs reset values without clk edge,
//    no rsp pulse; post-reset request completes normally.

Source files
------------

// File: rtl/spi_types.sv
`default_nettype none
// ============================================================================
// spi_types : SPI transaction modes shared by the controller and its clients
// Rev 1.0
// ============================================================================
package spi_types;

    typedef enum logic [2:0] {
        WRITE_8         = 3'd0,
        WRITE_16        = 3'd1,
        READ_8          = 3'd2,
        READ_16         = 3'd3,
        WRITE_8_READ_8  = 3'd4,
        WRITE_8_READ_16 = 3'd5,
        WRITE_8_READ_24 = 3'd6
    } spi_transaction_t;

    // Any encoding outside the two pure writes returns data, including unused codes.
    function automatic logic is_read_mode(input spi_transaction_t mode);
        return !(mode == WRITE_8 || mode == WRITE_16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// rr_priority_picker : first set request at or above a rotating pointer (wraps)
// Rev 1.0
// ============================================================================
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the closest requester wins last.
    always_comb begin
        gnt_idx_o = '0;
        gnt_oh_o  = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                gnt_idx_o = cand[IDX_W-1:0];
            end
        end
        any_o = |req_i;
        for (int i = 0; i < N; i++) begin
            gnt_oh_o[i] = any_o && (gnt_idx_o == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// spi_arbiter : round-robin sharing of one spi_controller with lock and watchdog
// Rev 1.0
// ============================================================================
module spi_arbiter
    import spi_types::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int TIMEOUT = 4096,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  spi_transaction_t [N_REQ-1:0]  req_mode,
    input  logic [N_REQ-1:0][15:0]        req_data,
    input  logic [N_REQ-1:0]              req_lock,
    output logic [N_REQ-1:0]              rsp_done,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [N_REQ-1:0]              rsp_err,
    output logic [23:0]                   rsp_data,
    output logic                          spi_i_valid,
    input  logic                          spi_i_ready,
    output spi_transaction_t              spi_mode,
    output logic [15:0]                   spi_i_data,
    input  logic [23:0]                   spi_o_data,
    output logic [IDX_W-1:0]              grant,
    output logic                          busy
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] grant_q;
    logic             lock_held_q;
    logic             spi_i_valid_q;
    spi_transaction_t spi_mode_q;
    logic [15:0]      spi_i_data_q;
    logic [N_REQ-1:0] rsp_done_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [N_REQ-1:0] rsp_err_q;
    logic [23:0]      rsp_data_q;
    logic [WD_W-1:0]  wd_q;

    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [N_REQ-1:0] grant_oh;
    logic [IDX_W-1:0] rr_adv;
    logic             wd_abort;

    assign grant_oh = N_REQ'(1) << grant_q;

    // A held lock narrows eligibility to the owner, even if it has nothing pending.
    assign elig     = lock_held_q ? (req_valid & grant_oh) : req_valid;
    assign pick_ptr = lock_held_q ? grant_q : rr_q;

    rr_priority_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i     (elig),
        .ptr_i     (pick_ptr),
        .gnt_oh_o  (win_oh),
        .gnt_idx_o (win_idx),
        .any_o     (win_any)
    );

    assign req_ready = (state_q == S_IDLE) ? win_oh : '0;
    assign rr_adv    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    // Completion in S_WAIT_DONE takes precedence over an expiring watchdog.
    assign wd_abort = (wd_q == WD_W'(TIMEOUT - 1)) &&
                      ((state_q == S_WAIT_BUSY) ||
                       (state_q == S_WAIT_DONE && !spi_i_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            grant_q       <= '0;
            lock_held_q   <= 1'b0;
            spi_i_valid_q <= 1'b0;
            spi_mode_q    <= WRITE_8;
            spi_i_data_q  <= '0;
            rsp_done_q    <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
            rsp_data_q    <= '0;
            wd_q          <= '0;
        end else begin
            rsp_done_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            if (wd_abort) begin
                rsp_err_q   <= grant_oh;
                lock_held_q <= 1'b0;
                rr_q        <= rr_adv;
                state_q     <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (win_any) begin
                            spi_mode_q    <= req_mode[win_idx];
                            spi_i_data_q  <= req_data[win_idx];
                            grant_q       <= win_idx;
                            spi_i_valid_q <= 1'b1;
                            state_q       <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (spi_i_ready) begin
                            spi_i_valid_q <= 1'b0;
                            wd_q          <= '0;
                            state_q       <= S_WAIT_BUSY;
                        end
                    end
                    S_WAIT_BUSY: begin
                        wd_q <= wd_q + WD_W'(1);
                        if (!spi_i_ready) begin
                            state_q <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (spi_i_ready) begin
                            rsp_done_q <= grant_oh;
                            if (is_read_mode(spi_mode_q)) begin
                                rsp_valid_q <= grant_oh;
                                rsp_data_q  <= spi_o_data;
                            end
                            lock_held_q <= req_lock[grant_q];
                            if (!req_lock[grant_q]) begin
                                rr_q <= rr_adv;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rsp_done    = rsp_done_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign spi_i_valid = spi_i_valid_q;
    assign spi_mode    = spi_mode_q;
    assign spi_i_data  = spi_i_data_q;
    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_arbiter : directed + randomized checks of spi_arbiter against a
// transaction-level round-robin/lock model and a behavioural SPI controller
// Rev 1.0
// ============================================================================
module tb_spi_arbiter;
    import spi_types::*;

    localparam int N  = 2;
    localparam int TO = 16;

    typedef struct packed {
        spi_transaction_t mode;
        logic [15:0]      data;
        logic             lock;
    } txn_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    spi_transaction_t [N-1:0] req_mode;
    logic [N-1:0][15:0]       req_data;
    logic [N-1:0]             req_lock;
    logic [N-1:0]             rsp_done;
    logic [N-1:0]             rsp_valid;
    logic [N-1:0]             rsp_err;
    logic [23:0]              rsp_data;
    logic                     spi_i_valid;
    logic                     spi_i_ready;
    spi_transaction_t         spi_mode;
    logic [15:0]              spi_i_data;
    logic [23:0]              spi_o_data;
    logic [0:0]               grant;
    logic                     busy;

    always #5 clk = ~clk;

    spi_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .rsp_done    (rsp_done),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_data    (rsp_data),
        .spi_i_valid (spi_i_valid),
        .spi_i_ready (spi_i_ready),
        .spi_mode    (spi_mode),
        .spi_i_data  (spi_i_data),
        .spi_o_data  (spi_o_data),
        .grant       (grant),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SPI controller: ready while idle, busy for a random time after a handshake.
    logic        ctl_hang     = 1'b0;
    logic        ctl_fixed_en = 1'b0;
    logic [23:0] ctl_fixed    = '0;
    txn_t        ctl_q[$];

    initial begin : ctl_model
        int   cnt;
        logic hs;
        spi_i_ready = 1'b1;
        spi_o_data  = '0;
        cnt         = 0;
        forever begin
            @(negedge clk);
            hs = spi_i_valid && spi_i_ready && !rst;
            if (hs) ctl_q.push_back('{mode: spi_mode, data: spi_i_data, lock: 1'b0});
            @(posedge clk);
            #1;
            if (rst) begin
                spi_i_ready = 1'b1;
                cnt         = 0;
            end else if (hs) begin
                spi_i_ready = 1'b0;
                cnt         = $urandom_range(1, 5);
            end else if (!spi_i_ready && !ctl_hang) begin
                if (cnt > 1) cnt--;
                else begin
                    spi_o_data  = ctl_fixed_en ? ctl_fixed : 24'($urandom);
                    spi_i_ready = 1'b1;
                end
            end
        end
    end

    // Transaction-level reference: per-requester lists, rr pointer, lock owner.
    txn_t        tl[N][32];
    int          tn[N];
    int          tp[N];
    int          rr_m   = 0;
    logic        lock_m = 1'b0;
    int          own_m  = 0;
    logic        infl   = 1'b0;
    txn_t        cur;
    logic [23:0] exp_rsp_data = '0;
    int          glog[$];

    function automatic logic mode_reads(input spi_transaction_t m);
        return (m != WRITE_8) && (m != WRITE_16);
    endfunction

    function automatic logic any_pend();
        for (int r = 0; r < N; r++) if (tp[r] < tn[r]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick();
        if (lock_m) return (tp[own_m] < tn[own_m]) ? own_m : -1;
        for (int k = 0; k < N; k++) begin
            int r = (rr_m + k) % N;
            if (tp[r] < tn[r]) return r;
        end
        return -1;
    endfunction

    task automatic clr();
        for (int r = 0; r < N; r++) begin
            tn[r] = 0;
            tp[r] = 0;
        end
        glog.delete();
    endtask

    task automatic add(input int r, input spi_transaction_t m, input logic [15:0] d, input logic l);
        tl[r][tn[r]] = '{mode: m, data: d, lock: l};
        tn[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            logic pend;
            pend = tp[r] < tn[r];
            req_valid[r] = pend;
            if (pend) begin
                req_mode[r] = tl[r][tp[r]].mode;
                req_data[r] = tl[r][tp[r]].data;
            end
            req_lock[r] = (infl && own_m == r) ? cur.lock : (pend ? tl[r][tp[r]].lock : 1'b0);
        end
    endtask

    task automatic run(input int maxc);
        int   c;
        int   w;
        txn_t acc;
        c = 0;
        drive();
        while ((infl || any_pend()) && c < maxc) begin
            @(negedge clk);
            c++;
            if (rsp_done != 0 || rsp_valid != 0 || rsp_err != 0) begin
                chk("rsp_err", rsp_err, 0);
                if (!infl) begin
                    chk("rsp_unexpected", rsp_done, 0);
                end else begin
                    chk("rsp_done", rsp_done, 1 << own_m);
                    chk("grant", grant, own_m);
                    if (mode_reads(cur.mode)) exp_rsp_data = spi_o_data;
                    chk("rsp_valid", rsp_valid, mode_reads(cur.mode) ? (1 << own_m) : 0);
                    chk("rsp_data", rsp_data, exp_rsp_data);
                    chk("ctl_issue_cnt", ctl_q.size(), 1);
                    if (ctl_q.size() > 0) begin
                        acc = ctl_q.pop_front();
                        chk("spi_mode", acc.mode, cur.mode);
                        chk("spi_i_data", acc.data, cur.data);
                    end
                    lock_m = cur.lock;
                    if (!cur.lock) rr_m = (own_m + 1) % N;
                    infl = 1'b0;
                end
            end
            w = infl ? -1 : pick();
            chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
            if (w >= 0 && req_ready[w]) begin
                cur   = tl[w][tp[w]];
                tp[w] = tp[w] + 1;
                own_m = w;
                infl  = 1'b1;
                glog.push_back(w);
            end
            @(posedge clk);
            #1;
            drive();
        end
        chk("run_timeout", (infl || any_pend()) ? 1 : 0, 0);
    endtask

    task automatic chk_seq(input string tag, input int exp[], input int n);
        chk({tag, "_len"}, glog.size(), n);
        for (int i = 0; i < n && i < glog.size(); i++) chk(tag, glog[i], exp[i]);
    endtask

    task automatic start_single(input int r, input spi_transaction_t m, input logic [15:0] d);
        int k;
        req_valid[r] = 1'b1;
        req_mode[r]  = m;
        req_data[r]  = d;
        req_lock[r]  = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready[r] && k < 20);
        chk("single_accept", req_ready[r], 1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(spi_i_valid && spi_i_ready) && k < 20);
        chk("single_issue", spi_i_valid && spi_i_ready, 1);
    endtask

    initial begin : main
        int k;
        int exp3[];
        int exp4[];
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_data  = '0;
        for (int r = 0; r < N; r++) req_mode[r] = WRITE_8;
        clr();

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_spi_i_valid", spi_i_valid, 0);
        chk("rst_spi_mode", spi_mode, WRITE_8);
        chk("rst_spi_i_data", spi_i_data, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_rsp", {rsp_done, rsp_valid, rsp_err, req_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from requester 0.
        clr();
        add(0, WRITE_16, 16'hA55A, 1'b0);
        run(200);
        chk("t1_grant", grant, 0);

        // Single read from requester 1 with a known controller result, then held through a write.
        ctl_fixed_en = 1'b1;
        ctl_fixed    = 24'h123456;
        clr();
        add(1, WRITE_8_READ_24, 16'h00C3, 1'b0);
        run(200);
        chk("t2_rsp_data", rsp_data, 24'h123456);
        ctl_fixed_en = 1'b0;
        clr();
        add(1, WRITE_8, 16'h0042, 1'b0);
        run(200);
        chk("t2_rsp_data_held", rsp_data, 24'h123456);

        // Contention: both requesters continuously valid for six transactions.
        clr();
        for (int i = 0; i < 3; i++) begin
            add(0, WRITE_16, 16'($urandom), 1'b0);
            add(1, WRITE_8, 16'($urandom), 1'b0);
        end
        run(400);
        exp3 = '{0, 1, 0, 1, 0, 1};
        chk_seq("t3_grant_seq", exp3, 6);

        // Lock: requester 0 keeps the grant for three writes while requester 1 waits.
        clr();
        add(0, WRITE_16, 16'h1111, 1'b1);
        add(0, WRITE_16, 16'h2222, 1'b1);
        add(0, WRITE_16, 16'h3333, 1'b0);
        add(1, WRITE_8, 16'h4444, 1'b0);
        run(400);
        exp4 = '{0, 0, 0, 1};
        chk_seq("t4_grant_seq", exp4, 4);

        // Watchdog: controller never finishes; abort 16 clocks after its handshake edge.
        ctl_hang = 1'b1;
        start_single(1, WRITE_8, 16'h5A5A);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rsp_err == 0 && k < 40);
        chk("wd_cycles", k - 1, 16);
        chk("wd_rsp_err", rsp_err, 2'b10);
        chk("wd_no_done", {rsp_done, rsp_valid}, 0);
        chk("wd_busy", busy, 0);
        chk("wd_ctl_cnt", ctl_q.size(), 1);
        ctl_q.delete();
        lock_m = 1'b0;
        rr_m   = (1 + 1) % N;
        infl   = 1'b0;
        @(posedge clk);
        #1;
        ctl_hang = 1'b0;
        clr();
        add(0, WRITE_8_READ_16, 16'h0BAD, 1'b0);
        add(1, WRITE_16, 16'hF00D, 1'b0);
        run(400);

        // Randomized traffic with random modes, data and locks.
        clr();
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < 12; i++) begin
                add(r, spi_transaction_t'($urandom_range(0, 7)), 16'($urandom),
                    (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end
        run(3000);

        // Asynchronous reset while waiting for the controller to finish.
        ctl_fixed_en = 1'b1;
        ctl_fixed    = 24'hABCDEF;
        clr();
        add(0, WRITE_8_READ_24, 16'h0001, 1'b0);
        run(200);
        ctl_fixed_en = 1'b0;
        ctl_hang     = 1'b1;
        start_single(1, WRITE_16, 16'hBEEF);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_spi_i_valid", spi_i_valid, 0);
        chk("t6_spi_mode", spi_mode, WRITE_8);
        chk("t6_spi_i_data", spi_i_data, 0);
        chk("t6_rsp_data", rsp_data, 0);
        chk("t6_grant", grant, 0);
        chk("t6_rsp", {rsp_done, rsp_valid, rsp_err, req_ready}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_rsp_in_rst", {rsp_done, rsp_valid, rsp_err}, 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ctl_hang = 1'b0;
        ctl_q.delete();
        rr_m         = 0;
        lock_m       = 1'b0;
        infl         = 1'b0;
        exp_rsp_data = '0;
        @(negedge clk);
        chk("t6_rsp_after_rst", {rsp_done, rsp_valid, rsp_err}, 0);
        @(posedge clk);
        #1;
        clr();
        add(1, READ_16, 16'h7777, 1'b0);
        run(200);
        chk("t6_post_grant", grant, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : tb_guard
        #500000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
